coarse_peak_finder: RTL and testbench



---
 rtl/coarse_peak_finder_if.sv | 27 ++
 rtl/coarse_peak_finder.sv | 102 ++++++++++
 tb/tb_coarse_peak_finder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/coarse_peak_finder_if.sv
// Port bundle for coarse_peak_finder: frame control, TDC hit stream and peak result.
// dbgState mirrors the internal FSM encoding (IDLE=0, CLEAR=1, ACQ=2, SCAN=3, DONE=4).
interface coarse_peak_finder_if #(
  parameter int NB = 4,
  parameter int NP = 12,
  parameter int CW = 8
);
  logic          start;
  logic          laserSync;
  logic          tdcValid;
  logic [NP-1:0] tdcData;
  logic [NB-1:0] peakCH;
  logic [CW-1:0] peakCount;
  logic          peakDone;
  logic          busy;
  logic [2:0]    dbgState;

  modport master (
    output start, laserSync, tdcValid, tdcData,
    input  peakCH, peakCount, peakDone, busy, dbgState
  );

  modport slave (
    input  start, laserSync, tdcValid, tdcData,
    output peakCH, peakCount, peakDone, busy, dbgState
  );
endinterface

// File: rtl/coarse_peak_finder.sv
// Coarse histogram over NCYC laser cycles: bins hits by their top NB timestamp bits,
// then scans the bins in order and reports the lowest-index most-populated bin.
module coarse_peak_finder #(
  parameter int NB   = 4,
  parameter int NP   = 12,
  parameter int CW   = 8,
  parameter int NCYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  coarse_peak_finder_if.slave  bus
);
  localparam int BINS = 2 ** NB;
  localparam int FW   = $clog2(NCYC + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACQ, SCAN, DONE} stateE;

  stateE         state, nextState;
  logic          startQ;
  logic [FW-1:0] frameCnt;
  logic [NB-1:0] idx;
  logic [CW-1:0] maxCount;
  logic [NB-1:0] maxIdx;
  logic [CW-1:0] binMem [BINS];

  logic [NB-1:0] hitBin;
  logic          acqOpen;
  logic          lastIdx;
  logic [CW-1:0] scanVal;
  logic          scanGreater;
  logic          unusedLow;

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE; the result is
  // offered as a level (peakDone) that stays up until the next accepted start.
  assign hitBin      = bus.tdcData[NP-1:NP-NB];
  assign unusedLow   = ^bus.tdcData[NP-NB-1:0];
  // The cycle after the final laserSync is a drain cycle: no further hits are binned.
  assign acqOpen     = (state == ACQ) && (frameCnt != FW'(NCYC));
  assign lastIdx     = (idx == {NB{1'b1}});
  assign scanVal     = binMem[idx];
  assign scanGreater = (scanVal > maxCount);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startQ) nextState = CLEAR;
      CLEAR:   if (lastIdx) nextState = ACQ;
      ACQ:     if (frameCnt == FW'(NCYC)) nextState = SCAN;
      SCAN:    if (lastIdx) nextState = DONE;
      DONE:    if (startQ) nextState = CLEAR;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      startQ        <= 1'b0;
      frameCnt      <= '0;
      idx           <= '0;
      maxCount      <= '0;
      maxIdx        <= '0;
      bus.peakCH    <= '0;
      bus.peakCount <= '0;
    end else begin
      state  <= nextState;
      startQ <= bus.start && ((state == IDLE) || (state == DONE));
      idx    <= ((state == CLEAR) || (state == SCAN)) ? idx + 1'b1 : '0;

      if (state == CLEAR)
        frameCnt <= '0;
      else if (acqOpen && bus.laserSync)
        frameCnt <= frameCnt + 1'b1;

      if (state != SCAN) begin
        maxCount <= '0;
        maxIdx   <= '0;
      end else if (scanGreater) begin
        maxCount <= scanVal;
        maxIdx   <= idx;
      end

      // The last bin is folded in on the same edge that publishes the result.
      if ((state == SCAN) && lastIdx) begin
        bus.peakCH    <= scanGreater ? idx : maxIdx;
        bus.peakCount <= scanGreater ? scanVal : maxCount;
      end
    end
  end

  // Bin storage needs no reset: CLEAR rewrites every entry before a frame uses it.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      binMem[idx] <= '0;
    else if (acqOpen && bus.tdcValid && (binMem[hitBin] != {CW{1'b1}}))
      binMem[hitBin] <= binMem[hitBin] + 1'b1;
  end

  assign bus.peakDone = (state == DONE);
  assign bus.busy     = (state == CLEAR) || (state == ACQ) || (state == SCAN);
  assign bus.dbgState = state;
endmodule

// File: tb/tb_coarse_peak_finder.sv
// Bench for coarse_peak_finder: table of frames plus reset sequences, with a result queue
// filled when the final laserSync is driven and drained when peakDone rises.
module tb_coarse_peak_finder;
  localparam int NB   = 4;
  localparam int NP   = 12;
  localparam int CW   = 8;
  localparam int NCYC = 4;
  localparam int W    = NB + CW;

  typedef struct {
    logic [NP-1:0] addrA;
    int            nA;
    logic [NP-1:0] addrB;
    int            nB;
    bit            finalHit;
    logic [NP-1:0] finalAddr;
    bit            gate;
    logic [NB-1:0] expCH;
    logic [CW-1:0] expCount;
  } vecT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coarse_peak_finder_if #(.NB(NB), .NP(NP), .CW(CW)) bus ();

  coarse_peak_finder #(.NB(NB), .NP(NP), .CW(CW), .NCYC(NCYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int            nVec = 0;
  int            nMiss = 0;
  logic [W-1:0]  exp_q[$];
  logic [NB-1:0] lastCH = '0;
  logic [CW-1:0] lastCount = '0;
  vecT           vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    bus.start     = 1'b0;
    bus.laserSync = 1'b0;
    bus.tdcValid  = 1'b0;
    bus.tdcData   = '0;
  endtask

  task automatic driveCycle(input bit st, input bit sy, input bit va, input logic [NP-1:0] d);
    bus.start     = st;
    bus.laserSync = sy;
    bus.tdcValid  = va;
    bus.tdcData   = d;
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_ch"}, bus.peakCH, 0);
    check({tag, "_count"}, bus.peakCount, 0);
    check({tag, "_done"}, bus.peakDone, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic runFrame(input vecT v);
    logic [W-1:0] e;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_at_t0", bus.busy, 0);
    @(posedge clk);
    #1;
    check("busy_clear", bus.busy, 1);
    check("done_drop", bus.peakDone, 0);
    check("hold_ch", bus.peakCH, lastCH);
    check("hold_count", bus.peakCount, lastCount);
    for (int i = 0; i < 16; i++) begin
      if (v.gate) begin
        bus.tdcValid  = 1'b1;
        bus.tdcData   = 12'h500;
        bus.laserSync = 1'b1;
      end
      @(posedge clk);
      #1;
      idleInputs();
    end
    driveCycle(0, 1, 0, '0);
    for (int i = 0; i < v.nA; i++) driveCycle(0, 0, 1, v.addrA);
    driveCycle(0, 1, 0, '0);
    for (int i = 0; i < v.nB; i++) driveCycle(0, 0, 1, v.addrB);
    driveCycle(0, 1, 0, '0);
    exp_q.push_back({v.expCH, v.expCount});
    driveCycle(0, 1, v.finalHit, v.finalAddr);
    for (int i = 0; i < 16; i++) begin
      if (v.gate) begin
        bus.tdcValid = 1'b1;
        bus.tdcData  = 12'hA00;
        bus.start    = (i == 5);
      end
      @(posedge clk);
      #1;
      idleInputs();
    end
    check("done_early", bus.peakDone, 0);
    check("busy_scan", bus.busy, 1);
    @(posedge clk);
    #1;
    check("done_rise", bus.peakDone, 1);
    check("busy_done", bus.busy, 0);
    e = exp_q.pop_front();
    check("peak_ch", bus.peakCH, e[W-1:CW]);
    check("peak_count", bus.peakCount, e[CW-1:0]);
    lastCH    = e[W-1:CW];
    lastCount = e[CW-1:0];
    if (v.gate) begin
      repeat (20) @(posedge clk);
      #1;
      check("single_frame_done", bus.peakDone, 1);
      check("single_frame_busy", bus.busy, 0);
    end
  endtask

  initial begin
    vecT fin;
    idleInputs();
    rst_n = 1'b0;
    repeat (5) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.laserSync = 1'($urandom_range(0, 1));
      bus.tdcValid  = 1'($urandom_range(0, 1));
      bus.tdcData   = 12'($urandom);
      @(posedge clk);
      #1;
    end
    checkZero("in_reset");
    idleInputs();
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkZero("after_reset");

    vecs[0] = '{12'h350, 5, 12'h7FF, 2, 1'b0, 12'h000, 1'b0, 4'd3, 8'd5};
    vecs[1] = '{12'h9F0, 3, 12'h2A0, 3, 1'b0, 12'h000, 1'b0, 4'd2, 8'd3};
    vecs[2] = '{12'hFFF, 300, 12'h000, 1, 1'b0, 12'h000, 1'b0, 4'd15, 8'd255};
    vecs[3] = '{12'h000, 0, 12'h000, 0, 1'b0, 12'h000, 1'b1, 4'd0, 8'd0};
    for (int r = 4; r < 7; r++) begin
      int binA, binB, cA, cB;
      binA = $urandom_range(1, 15);
      binB = (binA % 15) + 1;
      cA   = $urandom_range(1, 20);
      cB   = $urandom_range(1, 20);
      vecs[r].addrA    = {4'(binA), 8'($urandom)};
      vecs[r].nA       = cA;
      vecs[r].addrB    = {4'(binB), 8'($urandom)};
      vecs[r].nB       = cB;
      vecs[r].finalHit = 1'b0;
      vecs[r].finalAddr = '0;
      vecs[r].gate     = 1'b0;
      if (cA > cB) begin
        vecs[r].expCH = 4'(binA); vecs[r].expCount = 8'(cA);
      end else if (cB > cA) begin
        vecs[r].expCH = 4'(binB); vecs[r].expCount = 8'(cB);
      end else begin
        vecs[r].expCH = 4'((binA < binB) ? binA : binB); vecs[r].expCount = 8'(cA);
      end
    end

    for (int i = 0; i < 7; i++) runFrame(vecs[i]);

    // Asynchronous reset in the middle of acquisition, then a hit on the final laserSync.
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    driveCycle(0, 1, 0, '0);
    for (int i = 0; i < 4; i++) driveCycle(0, 0, 1, 12'h512);
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lastCH    = '0;
    lastCount = '0;
    fin = '{12'h000, 0, 12'h000, 0, 1'b1, 12'h6C3, 1'b0, 4'd6, 8'd1};
    runFrame(fin);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end
endmodule
